// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state codes, register map and divisor limits for the MMIO UART transmitter
package uart_pkg;

  typedef logic [1:0] tx_state_e;
  localparam tx_state_e ST_IDLE  = 2'd0;
  localparam tx_state_e ST_START = 2'd1;
  localparam tx_state_e ST_DATA  = 2'd2;
  localparam tx_state_e ST_STOP  = 2'd3;

  // Register word index, taken from mmio_addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  localparam logic [15:0] DIV_MIN = 16'd16;

  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < DIV_MIN) ? DIV_MIN : value;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head read; caller guarantees legal push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO, status/ctrl/divisor registers and irq
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = CLOCK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mmio_addr,
  input  logic        mmio_wen,
  input  logic [31:0] mmio_wdata,
  input  logic        mmio_ren,
  output logic [31:0] mmio_rdata,
  output logic        tx,
  output logic        tx_busy,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            enable;
  logic            irq_en;
  logic [15:0]     div;
  logic            overflow;
  tx_state_e       state;
  logic [15:0]     frame_div;
  logic [15:0]     timer;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;

  logic [1:0]      sel;
  logic            wr_txdata, wr_status, wr_ctrl, wr_div;
  logic            fifo_push, fifo_pop, full, empty;
  logic [7:0]      fifo_rdata;
  logic [CW-1:0]   count;
  logic [7:0]      count8;
  logic            unused_ok;

  assign sel       = mmio_addr[3:2];
  assign wr_txdata = mmio_wen && (sel == REG_TXDATA);
  assign wr_status = mmio_wen && (sel == REG_STATUS);
  assign wr_ctrl   = mmio_wen && (sel == REG_CTRL);
  assign wr_div    = mmio_wen && (sel == REG_DIV);

  assign fifo_pop  = (state == ST_IDLE) && enable && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign fifo_push = wr_txdata && (!full || fifo_pop);
  assign tx_busy   = (state != ST_IDLE);
  assign count8    = 8'(count);
  assign unused_ok = ^{mmio_addr[1:0], mmio_wdata[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (mmio_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b1;
      irq_en   <= 1'b0;
      div      <= 16'(DIV_RESET);
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) {irq_en, enable} <= mmio_wdata[1:0];
      if (wr_div)  div <= clamp_div(mmio_wdata[15:0]);
      if (wr_txdata && full && !fifo_pop)
        overflow <= 1'b1;
      else if (wr_status && mmio_wdata[STAT_OVF])
        overflow <= 1'b0;
      irq <= irq_en && empty && !tx_busy;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_ren) begin
      case (sel)
        REG_STATUS: begin
          mmio_rdata[STAT_FULL]  = full;
          mmio_rdata[STAT_EMPTY] = empty;
          mmio_rdata[STAT_BUSY]  = tx_busy;
          mmio_rdata[STAT_OVF]   = overflow;
          mmio_rdata[15:8]       = count8;
        end
        REG_CTRL: mmio_rdata[1:0]  = {irq_en, enable};
        REG_DIV:  mmio_rdata[15:0] = div;
        default:  mmio_rdata = '0;
      endcase
    end
  end

  // Divisor is latched per frame so DIV writes never stretch a frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      frame_div <= 16'(DIV_RESET);
      timer     <= '0;
      shift     <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            state     <= ST_START;
            shift     <= fifo_rdata;
            frame_div <= div;
            timer     <= div - 16'd1;
            tx        <= 1'b0;
          end
        end
        ST_START: begin
          if (timer == '0) begin
            state   <= ST_DATA;
            tx      <= shift[0];
            bit_idx <= '0;
            timer   <= frame_div - 16'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        ST_DATA: begin
          if (timer == '0) begin
            timer <= frame_div - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shift[1];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          if (timer == '0) state <= ST_IDLE;
          else             timer <= timer - 16'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench: expected bytes queued on TXDATA writes, serial frames decoded and compared
module tb_uart_tx_mmio;

  logic        clk;
  logic        rst_n;
  logic [3:0]  mmio_addr;
  logic        mmio_wen;
  logic [31:0] mmio_wdata;
  logic        mmio_ren;
  logic [31:0] mmio_rdata;
  logic        tx;
  logic        tx_busy;
  logic        irq;

  uart_tx_mmio dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mmio_addr  (mmio_addr),
    .mmio_wen   (mmio_wen),
    .mmio_wdata (mmio_wdata),
    .mmio_ren   (mmio_ren),
    .mmio_rdata (mmio_rdata),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .irq        (irq)
  );

  localparam logic [3:0] A_TXDATA = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_CTRL   = 4'h8;
  localparam logic [3:0] A_DIV    = 4'hC;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t sbq[$];
  int   starts[$];
  int   checks;
  int   failures;
  int   cyc;
  int   frames_done;
  int   frames_exp;
  logic mon_en;
  logic mon_prev;
  exp_t mon_e;
  logic [7:0] mon_got;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered at a negedge; a write lands on the following posedge.
  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    mmio_addr  = addr;
    mmio_wdata = data;
    mmio_wen   = 1'b1;
    @(negedge clk);
    mmio_wen   = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
    mmio_addr = addr;
    mmio_ren  = 1'b1;
    #1;
    data      = mmio_rdata;
    mmio_ren  = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] data, input int div);
    exp_t e;
    e.data = data;
    e.div  = div;
    sbq.push_back(e);
    frames_exp++;
  endtask

  task automatic wait_all(input int budget);
    int n;
    n = 0;
    while (frames_done != frames_exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_timeout", frames_done, frames_exp);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", tx_busy, 1'b0);
  endtask

  // Serial monitor: samples each bit at its midpoint using the divisor queued with the byte.
  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && mon_prev && !tx) begin
        starts.push_back(cyc);
        if (sbq.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          repeat (mon_e.div / 2) @(negedge clk);
          check("start_bit", tx, 1'b0);
          for (int k = 0; k < 8; k++) begin
            repeat (mon_e.div) @(negedge clk);
            mon_got[k] = tx;
          end
          repeat (mon_e.div) @(negedge clk);
          check("stop_bit", tx, 1'b1);
          check("frame_data", mon_got, mon_e.data);
          frames_done++;
        end
      end
      mon_prev = tx;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int runs[$];
    logic run_val;
    int run_len;
    int n;

    checks      = 0;
    failures    = 0;
    frames_done = 0;
    frames_exp  = 0;
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    mmio_addr   = '0;
    mmio_wen    = 1'b0;
    mmio_wdata  = '0;
    mmio_ren    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_irq", irq, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    read_reg(A_STATUS, rd); check("reset_status", rd, 32'h2);
    read_reg(A_DIV, rd);    check("reset_div", rd, 32'd868);
    read_reg(A_CTRL, rd);   check("reset_ctrl", rd, 32'h1);

    // Reset in the middle of a frame
    @(negedge clk);
    write_reg(A_DIV, 32'd16);
    write_reg(A_TXDATA, 32'h55);
    repeat (5) @(negedge clk);
    check("prerst_tx_low", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_async", tx, 1'b1);
    check("rst_busy_async", tx_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_reg(A_STATUS, rd); check("rst2_status", rd, 32'h2);
    read_reg(A_DIV, rd);    check("rst2_div", rd, 32'd868);
    read_reg(A_CTRL, rd);   check("rst2_ctrl", rd, 32'h1);
    mon_en = 1'b1;

    // 0x55 at DIV=16: latency, bit lengths, busy length
    @(negedge clk);
    write_reg(A_DIV, 32'd16);
    expect_byte(8'h55, 16);
    write_reg(A_TXDATA, 32'h55);
    check("lat_pre", tx, 1'b1);
    @(negedge clk);
    check("lat_start", tx, 1'b0);
    run_val = tx;
    run_len = 0;
    n = 0;
    while (tx_busy && n < 1000) begin
      if (tx == run_val) run_len++;
      else begin
        runs.push_back(run_len);
        run_val = tx;
        run_len = 1;
      end
      n++;
      @(negedge clk);
    end
    runs.push_back(run_len);
    check("busy_len", n, 160);
    check("run_count", runs.size(), 10);
    foreach (runs[i]) check("bit_len", runs[i], 16);
    wait_all(500);

    // Fill with enable off, overflow, W1C, then drain in order
    write_reg(A_CTRL, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_byte(8'(i), 16);
      write_reg(A_TXDATA, 32'(i));
    end
    read_reg(A_STATUS, rd); check("fill_status", rd, 32'h0809);
    @(negedge clk);
    write_reg(A_STATUS, 32'h8);
    read_reg(A_STATUS, rd); check("w1c_status", rd, 32'h0801);
    @(negedge clk);
    starts.delete();
    write_reg(A_CTRL, 32'h1);
    wait_all(5000);
    check("burst_frames", starts.size(), 8);
    for (int i = 1; i < starts.size(); i++)
      check("burst_spacing", starts[i] - starts[i-1], 161);

    // DIV clamp and mid-frame DIV change
    wait_idle(500);
    write_reg(A_DIV, 32'd3);
    read_reg(A_DIV, rd); check("div_clamp", rd, 32'd16);
    @(negedge clk);
    write_reg(A_DIV, 32'd16);
    starts.delete();
    expect_byte(8'h55, 16);
    write_reg(A_TXDATA, 32'h55);
    repeat (40) @(negedge clk);
    write_reg(A_DIV, 32'd100);
    read_reg(A_DIV, rd); check("div_100", rd, 32'd100);
    @(negedge clk);
    expect_byte(8'hA3, 100);
    write_reg(A_TXDATA, 32'hA3);
    wait_all(5000);
    check("divchg_frames", starts.size(), 2);
    if (starts.size() == 2) begin
      check("divchg_spacing", starts[1] - starts[0], 161);
      wait_idle(500);
      check("divchg_frame_len", cyc - starts[1], 1000);
    end

    // irq behaviour
    write_reg(A_DIV, 32'd16);
    write_reg(A_CTRL, 32'h3);
    check("irq_before", irq, 1'b0);
    @(negedge clk);
    check("irq_idle", irq, 1'b1);
    expect_byte(8'h3C, 16);
    write_reg(A_TXDATA, 32'h3C);
    check("irq_push_edge", irq, 1'b1);
    @(negedge clk);
    check("irq_after_push", irq, 1'b0);
    repeat (50) @(negedge clk);
    check("irq_mid_frame", irq, 1'b0);
    wait_idle(500);
    check("irq_stop_end", irq, 1'b0);
    @(negedge clk);
    check("irq_rise", irq, 1'b1);
    wait_all(500);

    // Push into a full FIFO in the same cycle as a pop
    write_reg(A_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) begin
      expect_byte(8'hB0 + 8'(i), 16);
      write_reg(A_TXDATA, 32'hB0 + 32'(i));
    end
    write_reg(A_CTRL, 32'h1);
    expect_byte(8'hB8, 16);
    write_reg(A_TXDATA, 32'hB8);
    read_reg(A_STATUS, rd); check("pushpop_status", rd, 32'h0805);
    wait_all(3000);
    check("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
